// File: rtl/nn_classify_core.sv
// rtl/nn_classify_core.sv - pixel-window convolution and shape classifier core (option macro: NN_RELU_EN)
module nn_classify_core #(
  parameter int NUM_KERNELS = 2,
  parameter int NUM_SHAPES  = 4,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learn,
  input  logic              classify,
  input  logic [31:0]       pixels,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  output logic              wr_ready,
  output logic              mem_csb,
  output logic              mem_web,
  output logic              mem_oeb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        result
);

  typedef enum logic [2:0] {IDLE, LEARN, CLS_RD, CLS_DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_KERNELS + NUM_SHAPES - 1);
  localparam logic [ADDR_W-1:0] SHAPE_BASE = ADDR_W'(NUM_KERNELS);

  state_t state, state_nxt;

  logic [ADDR_W-1:0]  cnt;
  logic [31:0]        pix_q;
  logic               data_vld;
  logic [ADDR_W-1:0]  data_idx;
  logic signed [8:0]  feat [NUM_KERNELS];
  logic signed [19:0] max_score;
  logic [7:0]         best_idx;

  logic signed [17:0] conv;
  logic signed [17:0] pix_term;
  logic signed [17:0] ker_term;
  logic signed [8:0]  feat_new;
  logic signed [19:0] score;
  logic signed [19:0] feat_term;
  logic signed [19:0] wgt_term;
  logic [ADDR_W-1:0]  shape_off;
  logic [7:0]         shape_idx;
  logic               is_kernel;
  logic               shape_win;

  // State register; reset drops any operation in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; learn wins over classify, requests only seen in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (learn)         state_nxt = LEARN;
        else if (classify) state_nxt = CLS_RD;
      end
      LEARN:     if (wr_valid && cnt == LAST_ADDR) state_nxt = DONE;
      CLS_RD:    if (cnt == LAST_ADDR) state_nxt = CLS_DRAIN;
      CLS_DRAIN: state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Memory strobes and status outputs decoded from the current state
  always_comb begin
    mem_csb   = 1'b1;
    mem_web   = 1'b1;
    mem_oeb   = 1'b1;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ready  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LEARN: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          mem_csb   = 1'b0;
          mem_web   = 1'b0;
          mem_addr  = cnt;
          mem_wdata = wr_data;
        end
      end
      CLS_RD: begin
        mem_csb  = 1'b0;
        mem_oeb  = 1'b0;
        mem_addr = cnt;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Kernel convolution on the word returned this cycle: unsigned pixels times signed taps
  always_comb begin
    conv     = '0;
    pix_term = '0;
    ker_term = '0;
    for (int i = 0; i < 4; i++) begin
      pix_term = $signed({10'd0, pix_q[8*i +: 8]});
      ker_term = $signed({{10{mem_rdata[8*i+7]}}, mem_rdata[8*i +: 8]});
      conv     = conv + pix_term * ker_term;
    end
  end

  // Squash the convolution into an 8-bit feature (ReLU-unsigned or signed clamp)
  always_comb begin
    feat_new = '0;
`ifdef NN_RELU_EN
    if (conv < 18'sd0)        feat_new = 9'sd0;
    else if (conv > 18'sd255) feat_new = 9'sd255;
    else                      feat_new = $signed(conv[8:0]);
`else
    if (conv < -18'sd128)     feat_new = -9'sd128;
    else if (conv > 18'sd127) feat_new = 9'sd127;
    else                      feat_new = $signed(conv[8:0]);
`endif
  end

  // Shape score: dot product of stored features with the signed weight bytes
  always_comb begin
    score     = '0;
    feat_term = '0;
    wgt_term  = '0;
    for (int k = 0; k < NUM_KERNELS; k++) begin
      feat_term = $signed({{11{feat[k][8]}}, feat[k]});
      wgt_term  = $signed({{12{mem_rdata[8*k+7]}}, mem_rdata[8*k +: 8]});
      score     = score + feat_term * wgt_term;
    end
  end

  // Winner tracking; strict greater-than keeps the lower index on ties
  always_comb begin
    is_kernel = (data_idx < SHAPE_BASE);
    shape_off = data_idx - SHAPE_BASE;
    shape_idx = 8'(shape_off);
    shape_win = data_vld && !is_kernel && ((shape_off == '0) || (score > max_score));
  end

  // Counters, pixel capture, feature/score accumulation and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      pix_q     <= '0;
      data_vld  <= 1'b0;
      data_idx  <= '0;
      max_score <= '0;
      best_idx  <= '0;
      result    <= '0;
      for (int k = 0; k < NUM_KERNELS; k++) feat[k] <= '0;
    end else begin
      data_vld <= (state == CLS_RD);
      data_idx <= cnt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!learn && classify) pix_q <= pixels;
        end
        LEARN:   if (wr_valid) cnt <= cnt + 1'b1;
        CLS_RD:  cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
      for (int k = 0; k < NUM_KERNELS; k++) begin
        if (data_vld && data_idx == ADDR_W'(k)) feat[k] <= feat_new;
      end
      if (shape_win) begin
        max_score <= score;
        best_idx  <= shape_idx;
      end
      if (state == CLS_DRAIN) result <= shape_win ? shape_idx : best_idx;
    end
  end

endmodule

// File: tb/tb_nn_classify_core.sv
// tb/tb_nn_classify_core.sv - scoreboard bench for nn_classify_core with a synchronous memory model
module tb_nn_classify_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        learn;
  logic        classify;
  logic [31:0] pixels;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        mem_csb;
  logic        mem_web;
  logic        mem_oeb;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [7:0]  result;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:31];
  logic [31:0] words [0:5];
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [7:0]  exp_q [$];
  int          access_cnt = 0;

  nn_classify_core #(
    .NUM_KERNELS(2),
    .NUM_SHAPES (4),
    .ADDR_W     (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .learn    (learn),
    .classify (classify),
    .pixels   (pixels),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .mem_csb  (mem_csb),
    .mem_web  (mem_web),
    .mem_oeb  (mem_oeb),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after its address
  always @(posedge clk) begin
    if (!mem_csb) access_cnt++;
    if (!mem_csb && !mem_web) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (!mem_csb && !mem_oeb && mem_web) mem_rdata <= mem[mem_addr];
    else                                 mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic test_reset;
    learn = 0; classify = 0; pixels = 0; wr_valid = 0; wr_data = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if ({mem_csb, mem_web, mem_oeb} !== 3'b111) begin failures++; $display("FAIL reset_strobes got=%b exp=111", {mem_csb, mem_web, mem_oeb}); end
    checks++; if (mem_addr !== 5'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Writes words[0..5] through LEARN; optional one-cycle gap after index gap_after
  task automatic load_words(input int gap_after, input logic hold_cls, input logic [7:0] exp_res);
    wr_addr_q.delete();
    wr_data_q.delete();
    learn = 1'b1;
    classify = hold_cls;
    @(negedge clk);
    learn = 1'b0;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL learn_entered wr_ready got=%b exp=1", wr_ready); end
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data = words[i];
      @(negedge clk);
      if (i == gap_after) begin
        wr_valid = 1'b0;
        wr_data = 32'h0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL learn_gap_done got=%b exp=0", done); end
      end
    end
    wr_valid = 1'b0;
    wr_data = 32'h0;
    classify = 1'b0;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL learn_done got=%b exp=1", done); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL learn_wr_ready_after got=%b exp=0", wr_ready); end
    checks++; if (result !== exp_res) begin failures++; $display("FAIL learn_result_kept got=%0d exp=%0d", result, exp_res); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL learn_idle_busy got=%b exp=0", busy); end
    checks++; if (wr_addr_q.size() !== 6) begin failures++; $display("FAIL learn_write_count got=%0d exp=6", wr_addr_q.size()); end
  endtask

  // Scoreboard: expected winner queued at the request, checked when done pulses
  task automatic run_classify(input logic [31:0] pix, input logic [7:0] exp_res);
    int cyc;
    bit seen;
    logic [7:0] exp_v;
    pixels = pix;
    classify = 1'b1;
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1;
    classify = 1'b0;
    pixels = $urandom();
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL cls_busy got=%b exp=1", busy); end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    exp_v = exp_q.pop_front();
    checks++;
    if (!seen) begin
      failures++; $display("FAIL cls_timeout no done within 20 cycles exp_result=%0d", exp_v);
    end else begin
      if (cyc !== 8) begin failures++; $display("FAIL cls_latency got=%0d exp=8", cyc); end
      checks++; if (result !== exp_v) begin failures++; $display("FAIL cls_result got=%0d exp=%0d", result, exp_v); end
    end
    @(negedge clk);
  endtask

  task automatic test_learn;
    words[0] = 32'h0101_0101;
    words[1] = 32'hFFFF_FFFF;
    words[2] = 32'h0000_0001;
    words[3] = 32'h0000_0002;
    words[4] = 32'h0000_05FF;
    words[5] = 32'h0000_0702;
    load_words(2, 1'b0, 8'd0);
    for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
      checks++; if (wr_addr_q[i] !== i) begin failures++; $display("FAIL learn_addr[%0d] got=%0d exp=%0d", i, wr_addr_q[i], i); end
      checks++; if (wr_data_q[i] !== words[i]) begin failures++; $display("FAIL learn_data[%0d] got=%h exp=%h", i, wr_data_q[i], words[i]); end
    end
  endtask

  task automatic test_classify;
    // RELU on: 40,80,-40,80 ; RELU off: 40,80,-240,-200 -> shape 1 either way
    run_classify({4{8'd10}}, 8'd1);
  endtask

  task automatic test_back_to_back;
    run_classify(32'h0, 8'd0);
    run_classify({4{8'd10}}, 8'd1);
  endtask

  task automatic test_priority;
    load_words(99, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL priority_no_classify cycle=%0d busy=%b exp=0", i, busy); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int done_cnt;
    pixels = {4{8'd10}};
    classify = 1'b1;
    @(posedge clk);
    #1 classify = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (result !== 8'd0) begin failures++; $display("FAIL midrst_result got=%0d exp=0", result); end
    checks++; if ({mem_csb, mem_web, mem_oeb} !== 3'b111) begin failures++; $display("FAIL midrst_strobes got=%b exp=111", {mem_csb, mem_web, mem_oeb}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    access_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL midrst_done_pulses got=%0d exp=0", done_cnt); end
    checks++; if (access_cnt !== 0) begin failures++; $display("FAIL midrst_mem_accesses got=%0d exp=0", access_cnt); end
    run_classify({4{8'd10}}, 8'd1);
  endtask

  task automatic test_saturation;
    words[0] = 32'h7F7F_7F7F;
    words[1] = 32'h0000_0000;
    words[2] = 32'h0000_0001;
    words[3] = 32'h0;
    words[4] = 32'h0;
    words[5] = 32'h0;
    load_words(99, 1'b0, 8'd1);
    run_classify(32'hFFFF_FFFF, 8'd0);
    // Kernel1 drives conv to -130560: ReLU gives 0, signed clamp gives -128 and shape 1 wins with 128
    words[1] = 32'h8080_8080;
    words[3] = 32'h0000_FF00;
    load_words(99, 1'b0, 8'd0);
`ifdef NN_RELU_EN
    run_classify(32'hFFFF_FFFF, 8'd0);
`else
    run_classify(32'hFFFF_FFFF, 8'd1);
`endif
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset;
    test_learn;
    test_classify;
    test_back_to_back;
    test_priority;
    test_reset_mid;
    test_saturation;
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nn_classify_core.md
NN_CLASSIFY_CORE -- requirements
Module: nn_classify_core

Interface
REQ-001 SHALL have parameter NUM_KERNELS, default 2, number of convolution kernels (legal range 1..4).
REQ-002 SHALL have parameter NUM_SHAPES, default 4, number of output classes (legal range 1..256).
REQ-003 SHALL have parameter ADDR_W, default 5, memory address width; must satisfy 2^ADDR_W >= NUM_KERNELS+NUM_SHAPES.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port learn  input  1  start-learn request, sampled in IDLE only.
REQ-007 SHALL have port classify  input  1  start-classify request, sampled in IDLE only.
REQ-008 SHALL have port pixels  input  4x8  unsigned pixel window, byte i = pixels[i].
REQ-009 SHALL have port wr_valid  input  1  learn-data strobe.
REQ-010 SHALL have port wr_data  input  32  learn data word.
REQ-011 SHALL have port wr_ready  output  1  high while in LEARN.
REQ-012 SHALL have ports mem_csb, mem_web, mem_oeb  output  1 each  active-low memory strobes.
REQ-013 SHALL have ports mem_addr  output  ADDR_W, mem_wdata  output  32, and mem_rdata  input  32.
REQ-014 SHALL have ports busy  output  1 (state != IDLE), done  output  1 (one-cycle completion pulse), result  output  8 (winning shape index).

Function
REQ-015 SHALL use memory map: addresses 0..K-1 hold kernel words, K..K+S-1 hold weight words, where K=NUM_KERNELS and S=NUM_SHAPES.
REQ-016 SHALL implement states IDLE, LEARN, CLS_RD, CLS_DRAIN, DONE; DONE lasts one cycle, then IDLE.
REQ-017 SHALL, in IDLE, prioritise learn over classify when both are high; requests outside IDLE are ignored.
REQ-018 SHALL, in LEARN, on each cycle with wr_valid high, drive csb=0, web=0, oeb=1, mem_wdata=wr_data, mem_addr=write counter, then increment the counter; after write K+S-1 go to DONE.
REQ-019 SHALL, on the edge sampling classify, register pixels; then drive mem_addr 0..K+S-1 on consecutive cycles with csb=0, oeb=0, web=1 (CLS_RD), then one CLS_DRAIN cycle.
REQ-020 SHALL treat mem_rdata as valid one cycle after its address.
REQ-021 SHALL compute kernel k as conv_k = sum over i of pixels[i] (unsigned) times rdata byte i (signed), at 18-bit signed width.
REQ-022 SHALL compute shape s score as sum over k of feature_k times weight byte k (signed), at 20-bit signed width.
REQ-023 SHALL track the running maximum score; on a tie the lower index is kept; shape 0 initialises the maximum.
REQ-024 SHALL register result and pulse done in DONE, K+S+2 cycles after the classify sampling edge (8 at defaults).
REQ-025 SHALL pulse done in DONE after learn, without changing result.
REQ-026 SHALL hold csb, web and oeb at 1 in all states not listed in REQ-018 and REQ-019.

Reset
REQ-027 SHALL, while rst=0, force state IDLE, result=0, done=0, busy=0, csb=web=oeb=1, mem_addr=0, and clear the counters, features and score registers.
REQ-028 SHALL, on reset asserted mid-operation, abandon the operation, issue no further memory access, and not pulse done.

Configuration
REQ-029 SHALL provide macro NN_RELU_EN; when defined, feature_k = 0 if conv_k<0, 255 if conv_k>255, else conv_k (8-bit unsigned).
REQ-030 SHALL, when NN_RELU_EN is undefined, make feature_k = conv_k clamped to -128..127 (8-bit signed); the score arithmetic stays signed.

Verification
REQ-031 SHALL cover learn at defaults: 6 wr_valid words, one with a 1-cycle gap -> addresses 0..5 written in order, done 1 cycle after last write, wr_ready low after.
REQ-032 SHALL cover classify with RELU on: pixels all 10, kernels {1,1,1,1},{-1,-1,-1,-1}, weights {1,0},{2,0},{-1,5},{2,7} -> scores 40,80,-40,80, result=1 (tie), done at cycle 8.
REQ-033 SHALL cover the same stimulus with RELU off -> scores 40,80,-240,-200, result=1.
REQ-034 SHALL cover saturation: pixels all 255, kernel0 {127}x4, weight0 {1,0}, others 0 -> feature0=255, result=0.
REQ-035 SHALL cover simultaneous learn+classify in IDLE -> LEARN entered; classify pulse during busy -> ignored.
REQ-036 SHALL cover rst low at cycle 3 of classify -> result=0, strobes high, no done, and the next classify completes normally.
